// File: rtl/rsa_pkg.sv
// rsa_pkg: shared state encoding, default sizing and phase indices for the RSA sequencer
package rsa_pkg;
    localparam int WIDTH_D   = 8;
    localparam int CNT_W_D   = 16;
    localparam int TIMEOUT_D = 4096;
    localparam logic [1:0] PH_KG  = 2'd0;
    localparam logic [1:0] PH_ENC = 2'd1;
    localparam logic [1:0] PH_DEC = 2'd2;
    typedef enum logic [3:0] {
        IDLE, LATCH, KG_GO, KG_WAIT, ENC_GO, ENC_WAIT, DEC_GO, DEC_WAIT, FIN
    } state_t;
endpackage

// File: rtl/rsa_phase_timer.sv
// rsa_phase_timer: shared saturating phase counter with watchdog compare
module rsa_phase_timer
    import rsa_pkg::*;
#(
    parameter int CNT_W   = CNT_W_D,
    parameter int TIMEOUT = TIMEOUT_D
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             tmo
);
    logic [CNT_W:0] cnt_p1;
    assign cnt_p1 = {1'b0, cnt} + (CNT_W+1)'(1);
    // tmo flags the cycle whose would-be latency reaches TIMEOUT
    assign tmo = inc && (cnt_p1 == (CNT_W+1)'(TIMEOUT));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && !(&cnt))
            cnt <= cnt_p1[CNT_W-1:0];
    end
endmodule

// File: rtl/rsa_seq_ctrl.sv
// rsa_seq_ctrl: sequences KeyGen -> encrypt -> decrypt, measuring per-phase latency
module rsa_seq_ctrl
    import rsa_pkg::*;
#(
    parameter int WIDTH   = WIDTH_D,
    parameter int CNT_W   = CNT_W_D,
    parameter int TIMEOUT = TIMEOUT_D
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   p,
    input  logic [WIDTH-1:0]   q,
    input  logic [WIDTH-1:0]   m,
    output logic               keygen_start,
    output logic               enc_start,
    output logic               dec_start,
    input  logic               keygen_finish,
    input  logic               enc_finish,
    input  logic               dec_finish,
    output logic               p_q_m_valid,
    output logic [WIDTH-1:0]   p_r,
    output logic [WIDTH-1:0]   q_r,
    output logic [WIDTH-1:0]   m_r,
    output logic [2*WIDTH-1:0] n,
    input  logic [WIDTH-1:0]   m_decrypted,
    output logic               busy,
    output logic               done,
    output logic               match,
    output logic               timeout,
    output logic [CNT_W-1:0]   kg_cycles,
    output logic [CNT_W-1:0]   enc_cycles,
    output logic [CNT_W-1:0]   dec_cycles
);
    state_t state, state_nx;
    logic [1:0] phase;
    logic waiting, go, fin_sel, tmo;
    logic [CNT_W-1:0] cnt, cnt_p1;

    assign phase   = (state == KG_GO || state == KG_WAIT)   ? PH_KG  :
                     (state == ENC_GO || state == ENC_WAIT) ? PH_ENC : PH_DEC;
    assign waiting = state inside {KG_WAIT, ENC_WAIT, DEC_WAIT};
    assign go      = state inside {KG_GO, ENC_GO, DEC_GO};
    // only the active phase's finish is ever looked at
    assign fin_sel = phase == PH_KG ? keygen_finish : phase == PH_ENC ? enc_finish : dec_finish;
    assign cnt_p1  = cnt + CNT_W'(1);

    assign keygen_start = state == KG_GO;
    assign enc_start    = state == ENC_GO;
    assign dec_start    = state == DEC_GO;
    assign busy         = state != IDLE;
    assign p_q_m_valid  = busy;
    assign done         = state == FIN;

    rsa_phase_timer #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (go),
        .inc  (waiting),
        .cnt  (cnt),
        .tmo  (tmo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     state_nx = start ? LATCH : IDLE;
            LATCH:    state_nx = KG_GO;
            KG_GO:    state_nx = KG_WAIT;
            KG_WAIT:  state_nx = fin_sel ? ENC_GO : tmo ? FIN : KG_WAIT;
            ENC_GO:   state_nx = ENC_WAIT;
            ENC_WAIT: state_nx = fin_sel ? DEC_GO : tmo ? FIN : ENC_WAIT;
            DEC_GO:   state_nx = DEC_WAIT;
            DEC_WAIT: state_nx = (fin_sel || tmo) ? FIN : DEC_WAIT;
            FIN:      state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_r        <= '0;
            q_r        <= '0;
            m_r        <= '0;
            n          <= '0;
            match      <= 1'b0;
            timeout    <= 1'b0;
            kg_cycles  <= '0;
            enc_cycles <= '0;
            dec_cycles <= '0;
        end else begin
            if (state == IDLE && start) begin
                p_r        <= p;
                q_r        <= q;
                m_r        <= m;
                match      <= 1'b0;
                timeout    <= 1'b0;
                kg_cycles  <= '0;
                enc_cycles <= '0;
                dec_cycles <= '0;
            end
            if (state == LATCH)
                n <= {{WIDTH{1'b0}}, p_r} * {{WIDTH{1'b0}}, q_r};
            if (waiting && fin_sel && phase == PH_KG)
                kg_cycles <= cnt_p1;
            if (waiting && fin_sel && phase == PH_ENC)
                enc_cycles <= cnt_p1;
            if (waiting && fin_sel && phase == PH_DEC)
                dec_cycles <= cnt_p1;
            // a finish coinciding with the watchdog wins
            if (waiting && !fin_sel && tmo)
                timeout <= 1'b1;
            if (state == FIN)
                match <= (m_decrypted == m_r) && !timeout;
        end
    end
endmodule
